// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexed QIF neuron scheduler: one shared update datapath swept across all neurons per tick.
// Optional per-neuron refractory skip is enabled by defining QIF_REFRACTORY_EN.
`timescale 1ns/1ps
module qif_neuron_scheduler #(
  parameter int               N_NEURONS  = 4,
  parameter logic signed [7:0] VPEAK     = 8'sd50,
  parameter logic signed [7:0] VRESET    = -8'sd20,
  parameter int               FIFO_DEPTH = 4,
  localparam int              IW         = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  output logic                 busy,
  output logic                 sweep_done,
  input  logic                 b_we,
  input  logic [IW-1:0]        b_addr,
  input  logic signed [7:0]    b_data,
  input  logic [IW-1:0]        v_rd_addr,
  output logic signed [7:0]    v_rd_data,
  output logic                 spk_valid,
  input  logic                 spk_ready,
  output logic [IW-1:0]        spk_id,
  output logic                 spk_overflow,
  output logic                 tick_overrun,
  input  logic                 clr_flags
);

  localparam int              NSLOT    = 1 << IW;
  localparam int              PW       = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0]   LAST_IDX = IW'(N_NEURONS - 1);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]     CNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            r_state, w_nextState;
  logic [IW-1:0]     r_idx;
  logic signed [7:0] r_v [NSLOT];
  logic signed [7:0] r_b [NSLOT];

  logic [IW-1:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wrPtr, r_rdPtr;
  logic [PW:0]       r_count;
  logic              r_overflow, r_overrun;

  logic signed [7:0]  w_curV, w_curB, w_satV, w_nextV;
  logic signed [15:0] w_vWide, w_bWide, w_bShift, w_sum;
  logic [15:0]        w_sq;
  logic               w_update, w_spike, w_refr, w_push, w_pop, w_full, w_doPush, w_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (tick) w_nextState = RUN;
      RUN:     if (r_idx == LAST_IDX) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_idx <= '0;
    else if (r_state == RUN && r_idx != LAST_IDX) r_idx <= r_idx + IDX_ONE;
    else if (r_state != RUN)                    r_idx <= '0;
  end

  assign busy       = (r_state != IDLE);
  assign sweep_done = (r_state == DONE);
  assign w_update   = (r_state == RUN);

  // QIF step: V + floor(B/4) + V^2/16, formed in 16 bits so nothing can wrap before saturation.
  assign w_curV   = r_v[r_idx];
  assign w_curB   = r_b[r_idx];
  assign w_vWide  = {{8{w_curV[7]}}, w_curV};
  assign w_bWide  = {{8{w_curB[7]}}, w_curB};
  assign w_bShift = w_bWide >>> 2;
  assign w_sq     = w_vWide * w_vWide;
  assign w_sum    = w_vWide + w_bShift + $signed(w_sq >> 4);
  assign w_spike  = (w_curV >= VPEAK);

  always_comb begin
    w_satV = w_sum[7:0];
    if (w_sum > 16'sd127)       w_satV = 8'sd127;
    else if (w_sum < -16'sd128) w_satV = -8'sd128;
  end

`ifdef QIF_REFRACTORY_EN
  logic [NSLOT-1:0] r_refr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_refr <= '0;
    else if (w_update) r_refr[r_idx] <= w_spike & ~r_refr[r_idx];
  end

  assign w_refr = r_refr[r_idx];
`else
  assign w_refr = 1'b0;
`endif

  assign w_nextV = (w_refr || w_spike) ? VRESET : w_satV;
  assign w_push  = w_update & w_spike & ~w_refr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) r_v[i] <= VRESET;
    end else if (w_update) begin
      r_v[r_idx] <= w_nextV;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) r_b[i] <= '0;
    end else if (b_we) begin
      r_b[b_addr] <= b_data;
    end
  end

  assign v_rd_data = r_v[v_rd_addr];

  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
  assign spk_valid = (r_count != '0);
  assign spk_id    = r_mem[r_rdPtr];
  assign w_pop     = spk_valid & spk_ready;
  assign w_full    = (r_count == CNT_FULL);
  assign w_doPush  = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= r_idx;
        r_wrPtr        <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_doPush, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_drop)                r_overflow <= 1'b1;
      else if (clr_flags)        r_overflow <= 1'b0;
      if (tick && r_state != IDLE) r_overrun <= 1'b1;
      else if (clr_flags)        r_overrun  <= 1'b0;
    end
  end

  assign spk_overflow = r_overflow;
  assign tick_overrun = r_overrun;

endmodule
